// File: rtl/mem_request_mux.sv
// Shared memory port front end: round-robin selection of one client per
// transaction, registered memory bus drive, and one-cycle ack with read data.
module mem_request_mux #(
    parameter int NUM_UNITS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_UNITS-1:0]            unit_req,
    input  logic [NUM_UNITS-1:0]            unit_write,
    input  logic [NUM_UNITS*ADDR_WIDTH-1:0] unit_addr,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_wdata,
    output logic [NUM_UNITS-1:0]            unit_ack,
    output logic [DATA_WIDTH-1:0]           unit_rdata,
    output logic                            mem_req,
    output logic                            mem_write,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic                            mem_ready,
    input  logic                            mem_done,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);

    localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t                 state;
    logic [NUM_UNITS-1:0]   grant;

    // ---------------- round-robin arbiter ----------------
    logic [NUM_UNITS-1:0]   arb_req;
    logic [NUM_UNITS-1:0]   grant_oh;
    logic [IW-1:0]          base;
    logic [IW-1:0]          next_base;
    logic                   found;
    int                     idx;

    // Only offer requests while idle, so the rotation moves once per grant
    assign arb_req = (state == IDLE) ? unit_req : '0;

    // Pick the first requester at or after the base pointer, wrapping
    always_comb begin
        grant_oh  = '0;
        next_base = base;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            idx = int'(base) + i;
            if (idx >= NUM_UNITS) begin
                idx = idx - NUM_UNITS;
            end
            if (!found && arb_req[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                if (idx == NUM_UNITS - 1) begin
                    next_base = '0;
                end else begin
                    next_base = IW'(idx + 1);
                end
            end
        end
    end

    // Advance the base past the winner whenever a grant is taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base <= '0;
        end else if (found) begin
            base <= next_base;
        end
    end

    // ---------------- winner field mux ----------------
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Route the one-hot winner's request fields toward the memory registers
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant_oh[i]) begin
                sel_write = unit_write[i];
                sel_addr  = unit_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = unit_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ---------------- transaction FSM ----------------
    // Grant, issue, wait for completion, then pulse ack back to the winner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            mem_req    <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            unit_ack   <= '0;
            unit_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    unit_ack <= '0;
                    if (found) begin
                        grant     <= grant_oh;
                        mem_req   <= 1'b1;
                        mem_write <= sel_write;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (mem_done) begin
                            unit_rdata <= mem_rdata;
                            unit_ack   <= grant;
                            state      <= ACK;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    mem_req <= 1'b0;
                    if (mem_done) begin
                        unit_rdata <= mem_rdata;
                        unit_ack   <= grant;
                        state      <= ACK;
                    end
                end
                ACK: begin
                    unit_ack <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_mux.sv
// Directed bench for mem_request_mux: reset, latency, fairness, stalls,
// write via WAIT path, late requester, spurious done, reset mid-WAIT.
module tb_mem_request_mux;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            reset;
    logic [N-1:0]    unit_req;
    logic [N-1:0]    unit_write;
    logic [N*AW-1:0] unit_addr;
    logic [N*DW-1:0] unit_wdata;
    logic [N-1:0]    unit_ack;
    logic [DW-1:0]   unit_rdata;
    logic            mem_req;
    logic            mem_write;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ready;
    logic            mem_done;
    logic [DW-1:0]   mem_rdata;

    int n_assert;
    int n_fail;

    logic [AW-1:0] addr_tab [N];
    logic [DW-1:0] wdat_tab [N];

    mem_request_mux #(
        .NUM_UNITS (N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .unit_req  (unit_req),
        .unit_write(unit_write),
        .unit_addr (unit_addr),
        .unit_wdata(unit_wdata),
        .unit_ack  (unit_ack),
        .unit_rdata(unit_rdata),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        addr_tab[0] = 32'h0000_0200;
        addr_tab[1] = 32'h0000_0111;
        addr_tab[2] = 32'h0000_0100;
        addr_tab[3] = 32'h0000_0300;
        wdat_tab[0] = 32'h0000_0055;
        wdat_tab[1] = 32'h0000_0011;
        wdat_tab[2] = 32'h0000_0022;
        wdat_tab[3] = 32'hDEAD_BEEF;
        for (int i = 0; i < N; i++) begin
            unit_addr[i*AW +: AW]  = addr_tab[i];
            unit_wdata[i*DW +: DW] = wdat_tab[i];
        end
        unit_write = 4'b1000;
        unit_req   = '0;
        mem_ready  = 1'b0;
        mem_done   = 1'b0;
        mem_rdata  = '0;
        reset      = 1'b1;

        // reset state
        tick();
        tick();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_unit_ack", 64'(unit_ack), 64'd0);
        chk("rst_unit_rdata", 64'(unit_rdata), 64'd0);
        reset = 1'b0;
        tick();

        // 1: single read, ready+done on first ISSUE cycle
        unit_req  = 4'b0100;
        mem_ready = 1'b1;
        mem_done  = 1'b1;
        mem_rdata = 32'hCAFE_1234;
        tick();
        chk("t1_mem_req", 64'(mem_req), 64'd1);
        chk("t1_mem_addr", 64'(mem_addr), 64'h100);
        chk("t1_mem_write", 64'(mem_write), 64'd0);
        chk("t1_no_early_ack", 64'(unit_ack), 64'd0);
        tick();
        chk("t1_ack", 64'(unit_ack), 64'b0100);
        chk("t1_rdata", 64'(unit_rdata), 64'hCAFE_1234);
        chk("t1_mem_req_clr", 64'(mem_req), 64'd0);
        unit_req  = 4'b0000;
        mem_ready = 1'b0;
        mem_done  = 1'b0;
        tick();
        chk("t1_ack_1cyc", 64'(unit_ack), 64'd0);

        // 2: all units requesting, rotation from a fresh base
        reset = 1'b1;
        tick();
        reset = 1'b0;
        unit_req  = 4'b1111;
        mem_ready = 1'b1;
        mem_done  = 1'b1;
        for (int t = 0; t < 8; t++) begin
            mem_rdata = 32'h1000 + 32'(t);
            for (int w = 0; w < 6; w++) begin
                tick();
                if (unit_ack != '0) break;
            end
            chk($sformatf("t2_ack_%0d", t), 64'(unit_ack),
                64'(4'b0001 << (t % 4)));
            chk($sformatf("t2_addr_%0d", t), 64'(mem_addr),
                64'(addr_tab[t % 4]));
            chk($sformatf("t2_rdata_%0d", t), 64'(unit_rdata),
                64'h1000 + 64'(t));
        end
        unit_req  = '0;
        mem_ready = 1'b0;
        mem_done  = 1'b0;
        tick();
        chk("t2_idle_ack", 64'(unit_ack), 64'd0);
        tick();

        // 3: mem_ready held low five cycles, unit 0 read
        unit_req = 4'b0001;
        tick();
        unit_req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t3_req_%0d", c), 64'(mem_req), 64'd1);
            chk($sformatf("t3_addr_%0d", c), 64'(mem_addr), 64'h200);
            chk($sformatf("t3_wdata_%0d", c), 64'(mem_wdata), 64'h55);
            chk($sformatf("t3_noack_%0d", c), 64'(unit_ack), 64'd0);
            tick();
        end
        mem_ready = 1'b1;
        mem_done  = 1'b1;
        mem_rdata = 32'h0000_0077;
        tick();
        chk("t3_ack", 64'(unit_ack), 64'b0001);
        chk("t3_rdata", 64'(unit_rdata), 64'h77);
        unit_req  = '0;
        mem_ready = 1'b0;
        mem_done  = 1'b0;
        tick();

        // 4: write by unit 3 through WAIT, done three cycles after ready
        unit_req = 4'b1000;
        tick();
        chk("t4_mem_req", 64'(mem_req), 64'd1);
        chk("t4_mem_write", 64'(mem_write), 64'd1);
        chk("t4_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        chk("t4_mem_addr", 64'(mem_addr), 64'h300);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("t4_req_clr", 64'(mem_req), 64'd0);
        chk("t4_wait_noack0", 64'(unit_ack), 64'd0);
        tick();
        chk("t4_wait_noack1", 64'(unit_ack), 64'd0);
        tick();
        chk("t4_wait_noack2", 64'(unit_ack), 64'd0);
        mem_done  = 1'b1;
        mem_rdata = 32'h0000_0099;
        tick();
        chk("t4_ack", 64'(unit_ack), 64'b1000);
        mem_done = 1'b0;
        unit_req = '0;
        tick();
        chk("t4_ack_clr", 64'(unit_ack), 64'd0);

        // 5: unit 1 active, unit 3 arrives during WAIT
        unit_req = 4'b0010;
        tick();
        chk("t5_addr_u1", 64'(mem_addr), 64'h111);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        unit_req  = 4'b1010;
        tick();
        chk("t5_wait_noack", 64'(unit_ack), 64'd0);
        mem_done  = 1'b1;
        mem_rdata = 32'h0000_ABCD;
        tick();
        chk("t5_ack_u1", 64'(unit_ack), 64'b0010);
        chk("t5_rdata_u1", 64'(unit_rdata), 64'hABCD);
        mem_done = 1'b0;
        unit_req = 4'b1000;
        tick();
        chk("t5_ack_clr", 64'(unit_ack), 64'd0);
        tick();
        chk("t5_u3_req", 64'(mem_req), 64'd1);
        chk("t5_u3_addr", 64'(mem_addr), 64'h300);
        mem_ready = 1'b1;
        mem_done  = 1'b1;
        tick();
        chk("t5_ack_u3", 64'(unit_ack), 64'b1000);
        unit_req  = '0;
        mem_ready = 1'b0;
        mem_done  = 1'b0;
        tick();
        mem_done  = 1'b1;
        mem_ready = 1'b1;
        tick();
        chk("t5_spur_ack0", 64'(unit_ack), 64'd0);
        tick();
        chk("t5_spur_ack1", 64'(unit_ack), 64'd0);
        chk("t5_spur_req", 64'(mem_req), 64'd0);
        mem_done  = 1'b0;
        mem_ready = 1'b0;

        // 6: reset mid-WAIT, then first grant goes to unit 0
        unit_req = 4'b0100;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("t6_rst_req", 64'(mem_req), 64'd0);
        chk("t6_rst_ack", 64'(unit_ack), 64'd0);
        chk("t6_rst_addr", 64'(mem_addr), 64'd0);
        unit_req = '0;
        mem_done = 1'b1;
        tick();
        chk("t6_rst_hold_ack", 64'(unit_ack), 64'd0);
        mem_done = 1'b0;
        reset    = 1'b0;
        tick();
        chk("t6_idle_ack", 64'(unit_ack), 64'd0);
        unit_req = 4'b1111;
        tick();
        chk("t6_first_addr", 64'(mem_addr), 64'h200);
        mem_ready = 1'b1;
        mem_done  = 1'b1;
        tick();
        chk("t6_first_ack", 64'(unit_ack), 64'b0001);
        unit_req  = '0;
        mem_ready = 1'b0;
        mem_done  = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
